// File: rtl/mem_access.sv
// Memory-access stage of the RV32I pipeline: runs loads/stores over a req/ack
// data port with wait states and a bus timeout, and produces the MEM/WB registers.
module mem_access #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        keep,
    input  logic        nop,
    input  logic [31:0] ALU_co_pype,
    input  logic [31:0] read_data2_pype2,
    input  logic [31:0] PCp4_pype2,
    input  logic [4:0]  WReg_pype2,
    input  logic [2:0]  writeback_control_pype2,
    input  logic [1:0]  MemRW_pype2,
    input  logic [1:0]  dsize_pype2,
    input  logic [2:0]  funct3_pype2,
    input  logic        d_ack,
    input  logic [31:0] d_rdata,
    output logic        d_req,
    output logic        d_we,
    output logic [31:0] d_addr,
    output logic [3:0]  d_be,
    output logic [31:0] d_wdata,
    output logic        mem_stall,
    output logic [31:0] wb_data_pype3,
    output logic [31:0] PCp4_pype3,
    output logic [4:0]  WReg_pype3,
    output logic [2:0]  writeback_control_pype3,
    output logic        misalign_pype3,
    output logic        bus_err_pype3
);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    typedef struct packed {
        logic [31:0] wb_data;
        logic [31:0] pcp4;
        logic [4:0]  wreg;
        logic [2:0]  wbc;
        logic        misalign;
        logic        bus_err;
    } memwb_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    memwb_t           r_memwb;
    memwb_t           r_buf;
    memwb_t           w_rec;

    logic        w_memop;
    logic        w_misalign;
    logic        w_busy;
    logic        w_at_limit;
    logic        w_done;
    logic        w_timeout;
    logic [1:0]  w_lane;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    assign w_lane     = ALU_co_pype[1:0];
    assign w_memop    = |MemRW_pype2;
    assign w_misalign = (dsize_pype2 == 2'b01 && w_lane[0]) ||
                        (dsize_pype2 == 2'b10 && w_lane != 2'b00);
    assign w_busy     = (r_state == BUSY);
    assign w_at_limit = (r_cnt == CNT_W'(MAX_WAIT));
    // Once the wait budget is spent the request is withdrawn, so a late ack is meaningless.
    assign w_done     = w_busy && !w_at_limit && d_ack;
    assign w_timeout  = w_busy && w_at_limit;

    assign d_req   = w_busy && !w_at_limit;
    assign d_we    = d_req && MemRW_pype2[0];
    assign d_addr  = w_busy ? {ALU_co_pype[31:2], 2'b00} : 32'h0;
    assign d_wdata = w_busy ? (read_data2_pype2 << {w_lane, 3'b000}) : 32'h0;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        d_be = 4'b0000;
        if (w_busy) begin
            case (dsize_pype2)
                2'b00:   d_be = 4'b0001 << w_lane;
                2'b01:   d_be = 4'b0011 << {w_lane[1], 1'b0};
                default: d_be = 4'b1111;
            endcase
        end
    end

    always_comb begin
        mem_stall = 1'b0;
        if (rst) begin
            case (r_state)
                IDLE:    mem_stall = !keep && !nop && w_memop && !w_misalign;
                BUSY:    mem_stall = !w_done && !w_timeout;
                HOLD:    mem_stall = keep;
                default: mem_stall = 1'b0;
            endcase
        end
    end

    assign w_byte = d_rdata[{w_lane, 3'b000} +: 8];
    assign w_half = w_lane[1] ? d_rdata[31:16] : d_rdata[15:0];

    always_comb begin
        case (funct3_pype2)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'h0, w_byte};
            3'b101:  w_load = {16'h0, w_half};
            default: w_load = d_rdata;
        endcase
    end

    // Record that would enter MEM/WB this cycle, for whichever path is active.
    always_comb begin
        w_rec.wb_data  = ALU_co_pype;
        w_rec.pcp4     = PCp4_pype2;
        w_rec.wreg     = WReg_pype2;
        w_rec.wbc      = writeback_control_pype2;
        w_rec.misalign = 1'b0;
        w_rec.bus_err  = 1'b0;
        if (w_busy) begin
            if (w_timeout) begin
                w_rec.wbc     = 3'b000;
                w_rec.bus_err = 1'b1;
            end else if (MemRW_pype2[1]) begin
                w_rec.wb_data = w_load;
            end
        end else if (w_memop && w_misalign) begin
            w_rec.wbc      = 3'b000;
            w_rec.wreg     = 5'd0;
            w_rec.misalign = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_memwb <= '0;
            r_buf   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!keep) begin
                        if (nop) begin
                            r_memwb <= '0;
                        end else if (!w_memop || w_misalign) begin
                            r_memwb <= w_rec;
                        end else begin
                            r_state <= BUSY;
                            r_cnt   <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (w_done || w_timeout) begin
                        if (keep) begin
                            r_buf   <= w_rec;
                            r_state <= HOLD;
                        end else begin
                            r_memwb <= w_rec;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (!keep) begin
                        r_memwb <= r_buf;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign wb_data_pype3           = r_memwb.wb_data;
    assign PCp4_pype3              = r_memwb.pcp4;
    assign WReg_pype3              = r_memwb.wreg;
    assign writeback_control_pype3 = r_memwb.wbc;
    assign misalign_pype3          = r_memwb.misalign;
    assign bus_err_pype3           = r_memwb.bus_err;

endmodule
